imm_gen_pipe: RTL

Two-stage pipelined immediate generator for the RV32/RV64 datapath, replacing the single-cycle combinational extender once decode is split into pipeline stages. It accepts one instruction per cycle over a valid/ready handshake, decodes all base-ISA immediate formats plus CSR and shift-amount immediates, and extends each result to `XLEN`. It sits between the instruction-fetch register and the execute-stage operand mux and honours stall (backpressure) and flush.

---
 rtl/imm_gen_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Two-stage pipelined immediate generator for the RV32/RV64 datapath. Accepts
// one instruction per cycle over a valid/ready handshake. It decodes the I, S,
// B, J, U, CSR-zimm and shift-amount immediate formats and extends the result
// to XLEN. Stage A registers the raw instruction and format select. Decode is
// combinational from stage A. Stage B is the output register. Backpressure
// propagates through a pass-through ready path, so a full pipe that is being
// drained still accepts input in the same cycle.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   FLUSH      in   synchronous kill of both stages; blocks same-cycle input
//   IN_VALID   in   INST/ImmSrc valid
//   IN_READY   out  input accepted this cycle when IN_VALID is also high
//   INST       in   raw 32-bit instruction word
//   ImmSrc     in   format select (111 is illegal)
//   OUT_VALID  out  ImmExt/IMM_ERR valid
//   OUT_READY  in   consumer takes the output this cycle
//   ImmExt     out  extended immediate, XLEN bits
//   IMM_ERR    out  output came from an illegal ImmSrc
//   IMM_CNT    out  count of completed output transfers, wraps at 16 bits
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
   parameter int XLEN         = 32,
   parameter int IMMSRC_WIDTH = 3
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    FLUSH,
   input  logic                    IN_VALID,
   output logic                    IN_READY,
   input  logic [31:0]             INST,
   input  logic [IMMSRC_WIDTH-1:0] ImmSrc,
   output logic                    OUT_VALID,
   input  logic                    OUT_READY,
   output logic [XLEN-1:0]         ImmExt,
   output logic                    IMM_ERR,
   output logic [15:0]             IMM_CNT
);

   typedef enum logic [2:0] {
      FMT_I   = 3'b000,
      FMT_S   = 3'b001,
      FMT_B   = 3'b010,
      FMT_J   = 3'b011,
      FMT_U   = 3'b100,
      FMT_Z   = 3'b101,
      FMT_SH  = 3'b110,
      FMT_ILL = 3'b111
   } imm_fmt_e;

   // Stage A
   logic [31:0]             a_inst;
   logic [IMMSRC_WIDTH-1:0] a_src;
   logic                    a_valid;

   // Handshake / advance
   logic b_en;
   logic a_en;
   logic in_xfer;
   logic out_xfer;

   // Decode of stage A
   logic [31:0]     imm32;
   logic            sext;
   logic            dec_err;
   logic [XLEN-1:0] dec_imm;

   // Opcode bits carry no immediate content.
   logic unused_opcode;
   assign unused_opcode = ^a_inst[6:0];

   assign b_en     = !OUT_VALID || OUT_READY;
   assign a_en     = !a_valid || b_en;
   assign IN_READY = a_en && !FLUSH;
   assign in_xfer  = IN_VALID && IN_READY;
   assign out_xfer = OUT_VALID && OUT_READY;

   // imm32 holds the immediate as a 32-bit pattern whose bit 31 is already
   // the sign for the sign-extended formats; widening to XLEN is done once.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      imm32   = '0;
      sext    = 1'b0;
      dec_err = 1'b0;
      unique case (imm_fmt_e'(a_src))
         FMT_I: begin
            imm32 = {{20{a_inst[31]}}, a_inst[31:20]};
            sext  = 1'b1;
         end
         FMT_S: begin
            imm32 = {{20{a_inst[31]}}, a_inst[31:25], a_inst[11:7]};
            sext  = 1'b1;
         end
         FMT_B: begin
            imm32 = {{19{a_inst[31]}}, a_inst[31], a_inst[7],
                     a_inst[30:25], a_inst[11:8], 1'b0};
            sext  = 1'b1;
         end
         FMT_J: begin
            imm32 = {{11{a_inst[31]}}, a_inst[31], a_inst[19:12],
                     a_inst[20], a_inst[30:21], 1'b0};
            sext  = 1'b1;
         end
         FMT_U: begin
            imm32 = {a_inst[31:12], 12'b0};
            sext  = 1'b1;
         end
         FMT_Z: begin
            imm32 = {27'b0, a_inst[19:15]};
         end
         FMT_SH: begin
            // RV64 shift amounts are 6 bits; RV32 uses only 5.
            imm32 = (XLEN == 64) ? {26'b0, a_inst[25:20]}
                                 : {27'b0, a_inst[24:20]};
         end
         FMT_ILL: begin
            dec_err = 1'b1;
         end
         default: begin
            dec_err = 1'b1;
         end
      endcase
      dec_imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_inst    <= '0;
         a_src     <= '0;
         a_valid   <= 1'b0;
         OUT_VALID <= 1'b0;
         ImmExt    <= '0;
         IMM_ERR   <= 1'b0;
         IMM_CNT   <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every register
         // sees pre-edge values, which the two stages rely on to shift cleanly.
         if (FLUSH) begin
            a_valid   <= 1'b0;
            OUT_VALID <= 1'b0;
         end else begin
            if (b_en) begin
               OUT_VALID <= a_valid;
               ImmExt    <= dec_imm;
               IMM_ERR   <= dec_err;
            end
            if (a_en) begin
               a_valid <= in_xfer;
               if (in_xfer) begin
                  a_inst <= INST;
                  a_src  <= ImmSrc;
               end
            end
         end
         // A handshake completes even in a flush cycle, so it still counts.
         if (out_xfer) begin
            IMM_CNT <= IMM_CNT + 16'd1;
         end
      end
   end

endmodule
